// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for counter_mod.
//   DIR_UP / DIR_DOWN : values of up_i
//   clamp_load        : saturates a load value into 0..modulo-1
//   params_ok         : elaboration-time legality check of the counter parameters
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values at or above the modulus saturate to the top count.
  function automatic longint unsigned clamp_load(input longint unsigned value,
                                                 input longint unsigned modulo);
    return (value < modulo) ? value : modulo - 64'd1;
  endfunction

  function automatic bit params_ok(input int unsigned     width,
                                   input longint unsigned modulo,
                                   input longint unsigned reset_value,
                                   input int unsigned     prescale);
    bit ok;
    ok = (width >= 1) && (width <= 32);
    ok = ok && (modulo >= 64'd2) && (modulo <= (64'd1 << width));
    ok = ok && (reset_value < modulo);
    ok = ok && (prescale >= 1) && (prescale <= 65536);
    return ok;
  endfunction

endpackage

// File: rtl/counter_mod_if.sv
// counter_mod_if: control and status bundle of counter_mod.
//   enable_i, up_i, clear_i, load_i, load_value_i : controls driven by the user
//   counter_value_o, wrap_o, terminal_o           : status driven by the counter
// Modports: master (user side), slave (counter side).
interface counter_mod_if #(
  parameter int unsigned WIDTH = 4
);

  logic             enable_i;
  logic             up_i;
  logic             clear_i;
  logic             load_i;
  logic [WIDTH-1:0] load_value_i;
  logic [WIDTH-1:0] counter_value_o;
  logic             wrap_o;
  logic             terminal_o;

  modport master (
    output enable_i, up_i, clear_i, load_i, load_value_i,
    input  counter_value_o, wrap_o, terminal_o
  );

  modport slave (
    input  enable_i, up_i, clear_i, load_i, load_value_i,
    output counter_value_o, wrap_o, terminal_o
  );

endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: counts enabled cycles 0..PRESCALE-1.
//   clock_i   : rising-edge clock
//   reset_i   : synchronous active-high reset (count -> 0)
//   restart_i : synchronous restart (count -> 0), overrides enable_i
//   enable_i  : advance the count
//   tick_o    : combinational, high while the count sits at PRESCALE-1
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned     CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;

  assign tick_o = (count_q == LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i || restart_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= tick_o ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/counter_mod.sv
// counter_mod: parametrised up/down modulo-MODULO counter.
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset
//   bus     : counter_mod_if.slave
//             enable_i/up_i/clear_i/load_i/load_value_i in,
//             counter_value_o (registered), wrap_o (registered pulse),
//             terminal_o (combinational: a step now would wrap)
// Priority per edge: reset_i > clear_i > load_i > enable_i > hold.
// Optional macro COUNTER_MOD_PRESCALER_EN: step only every PRESCALE enabled cycles.
module counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 4,
  parameter longint unsigned MODULO      = 16,
  parameter longint unsigned RESET_VALUE = 0,
  parameter int unsigned     PRESCALE    = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  counter_mod_if.slave bus
);

  if (!params_ok(WIDTH, MODULO, RESET_VALUE, PRESCALE)) begin : g_param_error
    $error("counter_mod: illegal WIDTH/MODULO/RESET_VALUE/PRESCALE combination");
  end

  // Boundary compare is done one bit wider so MODULO = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X   = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0]   MAX_X   = MOD_X - (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_V   = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] value_q;
  logic             wrap_q;
  logic [WIDTH:0]   value_x;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] next_down;
  logic [WIDTH-1:0] load_v;
  logic             step_en;
  logic             terminal;

`ifdef COUNTER_MOD_PRESCALER_EN
  logic tick;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .restart_i(bus.clear_i || bus.load_i),
    .enable_i (bus.enable_i),
    .tick_o   (tick)
  );
`endif

  always_comb begin
    value_x   = {1'b0, value_q};
    at_max    = (value_x == MAX_X);
    at_zero   = (value_q == '0);
    next_up   = at_max ? '0 : value_q + WIDTH'(1);
    next_down = at_zero ? MAX_V : value_q - WIDTH'(1);
    load_v    = WIDTH'(clamp_load(64'(bus.load_value_i), MODULO));
`ifdef COUNTER_MOD_PRESCALER_EN
    step_en   = bus.enable_i && tick;
    terminal  = ((bus.up_i == DIR_UP) ? at_max : at_zero) && tick;
`else
    step_en   = bus.enable_i;
    terminal  = (bus.up_i == DIR_UP) ? at_max : at_zero;
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || bus.clear_i) begin
      value_q <= RESET_V;
      wrap_q  <= 1'b0;
    end else if (bus.load_i) begin
      value_q <= load_v;
      wrap_q  <= 1'b0;
    end else if (step_en) begin
      value_q <= (bus.up_i == DIR_UP) ? next_up : next_down;
      wrap_q  <= (bus.up_i == DIR_UP) ? at_max : at_zero;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.counter_value_o = value_q;
  assign bus.wrap_o          = wrap_q;
  assign bus.terminal_o      = terminal;

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_mod_if #(.WIDTH(4)) if_a ();
  counter_mod_if #(.WIDTH(4)) if_b ();

  counter_mod #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0)) dut_a (
    .clock_i(clk), .reset_i(reset), .bus(if_a.slave));

  counter_mod #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) dut_b (
    .clock_i(clk), .reset_i(reset), .bus(if_b.slave));

`ifdef COUNTER_MOD_PRESCALER_EN
  counter_mod_if #(.WIDTH(4)) if_c ();
  counter_mod #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0), .PRESCALE(3)) dut_c (
    .clock_i(clk), .reset_i(reset), .bus(if_c.slave));
`endif

  typedef struct {
    logic       rst, clr, ld, en, up;
    logic [3:0] lv;
    logic [3:0] ev;
    logic       ew;
  } vec_t;

  typedef struct {
    logic [3:0] v;
    logic       w;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rst, logic clr, logic ld, logic en, logic up,
                              logic [3:0] lv, logic [3:0] ev, logic ew);
    vec_t r;
    r.rst = rst; r.clr = clr; r.ld = ld; r.en = en; r.up = up;
    r.lv = lv; r.ev = ev; r.ew = ew;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_all();
    if_a.enable_i = 0; if_a.up_i = 1; if_a.clear_i = 0; if_a.load_i = 0; if_a.load_value_i = '0;
    if_b.enable_i = 0; if_b.up_i = 1; if_b.clear_i = 0; if_b.load_i = 0; if_b.load_value_i = '0;
`ifdef COUNTER_MOD_PRESCALER_EN
    if_c.enable_i = 0; if_c.up_i = 1; if_c.clear_i = 0; if_c.load_i = 0; if_c.load_value_i = '0;
`endif
  endtask

  task automatic drive_b(input logic ld, input logic en, input logic up, input logic [3:0] lv);
    @(negedge clk);
    if_b.load_i = ld; if_b.enable_i = en; if_b.up_i = up; if_b.load_value_i = lv;
  endtask

`ifdef COUNTER_MOD_PRESCALER_EN
  task automatic step_c(input logic ld, input logic en, input logic [3:0] lv, input logic [3:0] ev,
                        input string name);
    @(negedge clk);
    if_c.load_i = ld; if_c.enable_i = en; if_c.up_i = 1; if_c.load_value_i = lv;
    @(posedge clk); #1;
    check(name, 64'(if_c.counter_value_o), 64'(ev));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] model_val;
    logic       term_exp;
    exp_t       e;

    reset = 1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", 64'(if_a.counter_value_o), 64'd0);
    check("reset_wrap", 64'(if_a.wrap_o), 64'd0);
    check("reset_terminal", 64'(if_a.terminal_o), 64'd0);
    model_val = 4'd0;

    // up count 1..9, 0 (wrap), 1, 2
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 4'd0, 4'(k % 10), (k == 10)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'd3, 4'd3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd9, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'd12, 4'd9, 0));  // clamp
    vecs.push_back(mk(0, 0, 1, 1, 1, 4'd5, 4'd5, 0));   // load beats enable
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'd7, 4'd7, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 4'd2, 4'd0, 0));   // clear beats load/enable
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'd9, 4'd9, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 4'd0, 4'd0, 0));   // reset on a would-be wrap
    vecs.push_back(mk(0, 0, 1, 0, 1, 4'd9, 4'd9, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'd0, 4'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 4'd0, 0));   // hold clears wrap
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'd0, 4'd1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0));   // direction change, no wrap
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd9, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'd0, 4'd0, 1));   // consecutive wraps
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'd15, 4'd9, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      if_a.clear_i = vecs[i].clr; if_a.load_i = vecs[i].ld; if_a.enable_i = vecs[i].en;
      if_a.up_i = vecs[i].up; if_a.load_value_i = vecs[i].lv;
      #1;
      term_exp = (vecs[i].up && model_val == 4'd9) || (!vecs[i].up && model_val == 4'd0);
      check($sformatf("a_terminal[%0d]", i), 64'(if_a.terminal_o), 64'(term_exp));
      sb.push_back('{v: vecs[i].ev, w: vecs[i].ew});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        check("a_scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("a_value[%0d]", i), 64'(if_a.counter_value_o), 64'(e.v));
        check($sformatf("a_wrap[%0d]", i), 64'(if_a.wrap_o), 64'(e.w));
        model_val = e.v;
      end
    end
    @(negedge clk);
    reset = 0;
    idle_all();

    // MODULO = 2**WIDTH: plain binary wrap both ways
    drive_b(1, 0, 1, 4'd15);
    @(posedge clk); #1;
    check("b_load15", 64'(if_b.counter_value_o), 64'd15);
    drive_b(0, 0, 1, 4'd0);
    #1;
    check("b_terminal_no_enable", 64'(if_b.terminal_o), 64'd1);
    drive_b(0, 1, 1, 4'd0);
    @(posedge clk); #1;
    check("b_up_wrap_value", 64'(if_b.counter_value_o), 64'd0);
    check("b_up_wrap_pulse", 64'(if_b.wrap_o), 64'd1);
    drive_b(0, 1, 0, 4'd0);
    #1;
    check("b_terminal_down", 64'(if_b.terminal_o), 64'd1);
    @(posedge clk); #1;
    check("b_down_wrap_value", 64'(if_b.counter_value_o), 64'd15);
    check("b_down_wrap_pulse", 64'(if_b.wrap_o), 64'd1);
    drive_b(0, 0, 0, 4'd0);
    @(posedge clk); #1;
    check("b_hold_value", 64'(if_b.counter_value_o), 64'd15);
    check("b_hold_wrap", 64'(if_b.wrap_o), 64'd0);

`ifdef COUNTER_MOD_PRESCALER_EN
    begin
      logic [3:0] pexp [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
      step_c(1, 0, 4'd0, 4'd0, "c_load0");
      for (int k = 0; k < 9; k++)
        step_c(0, 1, 4'd0, pexp[k], $sformatf("c_prescale[%0d]", k));
      step_c(0, 1, 4'd0, 4'd3, "c_mid_prescale");
      step_c(1, 1, 4'd5, 4'd5, "c_load_restart");
      step_c(0, 1, 4'd0, 4'd5, "c_after_load1");
      step_c(0, 1, 4'd0, 4'd5, "c_after_load2");
      step_c(0, 1, 4'd0, 4'd6, "c_after_load3");
      step_c(1, 0, 4'd9, 4'd9, "c_load9");
      @(negedge clk); if_c.enable_i = 0; #1;
      check("c_terminal_gated", 64'(if_c.terminal_o), 64'd0);
      step_c(0, 1, 4'd0, 4'd9, "c_pre1");
      step_c(0, 1, 4'd0, 4'd9, "c_pre2");
      @(negedge clk); if_c.enable_i = 0; #1;
      check("c_terminal_ready", 64'(if_c.terminal_o), 64'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
